serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial, LSB-first unsigned subtractor: diff = a - b, borrow_out = (a < b).
//  Inverse-direction companion to the combinational half/full adder cells.
//  Uses one subtractor bit cell plus a borrow flip-flop, stepped WIDTH times.
//  Sits beside the adder cells as the low-area arithmetic option for
//  testbench and datapath use.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 1
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend; captured on accepted start
//  b           in   WIDTH  subtrahend; captured on accepted start
//  busy        out  1      high while in SHIFT
//  done        out  1      one-cycle pulse: diff/borrow_out now valid
//  diff        out  WIDTH  result; held until the next accepted start
//  borrow_out  out  1      final borrow; held like diff
// BEHAVIOUR
//  Reset: rst async, active-high. Forces state=IDLE, busy=0, done=0, diff=0,
//   borrow_out=0, internal shift regs, borrow FF and bit counter all 0.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start=1 at edge -> load a_sh=a, b_sh=b, bor=0, cnt=0, enter SHIFT.
//   SHIFT: each edge computes one bit from a_sh[0], b_sh[0], bor:
//    d      = a0 ^ b0 ^ bor
//    bor_n  = (~a0 & b0) | (~(a0 ^ b0) & bor)
//    Shift d into the MSB of the result reg; shift a_sh and b_sh right.
//    Update bor and cnt. On the edge where cnt==WIDTH-1, enter DONE.
//    On that same edge, diff and borrow_out update.
//   DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//  Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH.
//   Throughput: one operation per WIDTH+2 cycles.
//  Outputs are Moore: busy=(state==SHIFT); done=(state==DONE).
//  start while SHIFT or DONE: ignored; not queued; a/b changes have no effect.
//  diff/borrow_out change only on the final SHIFT edge.
//   Intermediate shifting uses a separate internal reg; diff never shows
//   partial results.
//  Arithmetic: modulo 2^WIDTH; borrow_out=1 iff a<b (unsigned); a==b -> 0, 0.
//  rst asserted mid-SHIFT: abort immediately to reset values; no done pulse.
//  Counter width: $clog2(WIDTH), minimum 1 bit. WIDTH=1 -> one SHIFT cycle.
// STRUCTURE
//  Shared package/include: FSM state localparams
//   S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
//  Sub-module: full_subtractor (combinational bit cell: d, bo from a, b, bi).
//   Built from two half-subtractor stages plus an OR.
//   Instantiated once; the borrow FF and FSM live in serial_subtractor.
// TESTING
//  1. a=8'd10, b=8'd3, start 1 cycle -> busy 8 cycles;
//     done one cycle later; diff=8'd7, borrow_out=0.
//  2. a=8'd3, b=8'd10 -> diff=8'hF9, borrow_out=1.
//  3. a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1.
//     Then a=b=8'hA5 -> diff=8'h00, borrow_out=0.
//  4. start held high continuously, operands changed mid-SHIFT ->
//     only first operands used; next op starts the cycle after DONE.
//     Period is WIDTH+2 cycles.
//  5. rst pulsed at SHIFT cycle 4 -> all outputs 0 immediately; no done.
//     New start afterwards gives a correct result.
//  6. WIDTH=1 build, exhaustive a,b in {0,1} -> diff/borrow_out match the
//     half-subtractor truth table; done 2 cycles after start edge.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Width of the bit counter: enough to count 0..w-1, never less than 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor. The master side issues
// operands and start; the slave side (the subtractor) reports status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bi, bo = borrow out.
// Two half-subtractor stages joined by an OR on their borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic d1;
    logic b1;
    logic b2;

    // First half subtractor: a - b
    assign d1 = a ^ b;
    assign b1 = ~a & b;

    // Second half subtractor: (a - b) - bi
    assign d  = d1 ^ bi;
    assign b2 = ~d1 & bi;

    // A borrow is needed if either stage borrowed (they never both do)
    assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first unsigned subtractor: diff = a - b, borrow_out = (a < b).
// One full-subtractor cell is stepped WIDTH times; the running borrow lives in
// a flip-flop. Partial results accumulate in an internal shift register so the
// diff output only ever shows complete results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_n;
    logic [CNT_W-1:0] cnt;
    logic             bor;
    logic             bit_d;
    logic             bit_bo;
    logic             last;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    full_subtractor u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (bor),
        .d  (bit_d),
        .bo (bit_bo)
    );

    // New result bit enters at the MSB; after WIDTH steps bit 0 holds the LSB.
    assign res_n = (res_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    assign last  = (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.start) state_n = S_SHIFT;
            S_SHIFT: if (last)      state_n = S_DONE;
            S_DONE:                 state_n = S_IDLE;
            default:                state_n = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        bus.busy = (state == S_SHIFT);
        bus.done = (state == S_DONE);
    end

    // Datapath: load operands on accept, step one bit per SHIFT cycle,
    // publish diff/borrow only on the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            bor      <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (state == S_IDLE) begin
            if (bus.start) begin
                a_sh   <= bus.a;
                b_sh   <= bus.b;
                res_sh <= '0;
                bor    <= 1'b0;
                cnt    <= '0;
            end
        end else if (state == S_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_n;
            bor    <= bit_bo;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                diff_q   <= res_n;
                borrow_q <= bit_bo;
            end
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit and a 1-bit instance,
// table-driven vectors plus hand-written held-start and mid-operation reset
// sequences, with a queue scoreboard of expected results.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // cur selects which instance the shared driver/monitor signals address
    logic       cur;
    logic       start_r;
    logic [7:0] a_r;
    logic [7:0] b_r;

    assign bus8.start = start_r & ~cur;
    assign bus8.a     = a_r;
    assign bus8.b     = b_r;
    assign bus1.start = start_r & cur;
    assign bus1.a     = a_r[0];
    assign bus1.b     = b_r[0];

    logic       m_busy;
    logic       m_done;
    logic       m_bor;
    logic [7:0] m_diff;

    assign m_busy = cur ? bus1.busy       : bus8.busy;
    assign m_done = cur ? bus1.done       : bus8.done;
    assign m_bor  = cur ? bus1.borrow_out : bus8.borrow_out;
    assign m_diff = cur ? {7'd0, bus1.diff} : bus8.diff;

    typedef struct {
        logic [7:0] diff;
        logic       bor;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bor;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pop the oldest expected result and compare it with the DUT outputs
    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk_eq({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk_eq({name, "_diff"}, {24'd0, m_diff}, {24'd0, e.diff});
            chk_eq({name, "_borrow"}, {31'd0, m_bor}, {31'd0, e.bor});
        end
    endtask

    // One complete operation with a single-cycle start pulse
    task automatic run_op(input logic sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input string name);
        int         w;
        int         n;
        int         nbusy;
        logic       held;
        logic [7:0] prev;
        exp_t       e;
        w = sel ? 1 : 8;
        @(negedge clk);
        cur     = sel;
        a_r     = a;
        b_r     = b;
        start_r = 1'b1;
        e.diff  = ed;
        e.bor   = eb;
        sb.push_back(e);
        @(negedge clk);
        start_r = 1'b0;
        n       = 1;
        nbusy   = 0;
        held    = 1'b1;
        prev    = m_diff;
        while (!m_done && n < 40) begin
            if (m_busy) nbusy++;
            if (m_diff !== prev) held = 1'b0;
            @(negedge clk);
            n++;
        end
        chk_eq({name, "_done_latency"}, 32'(n), 32'(w + 1));
        chk_eq({name, "_busy_cycles"}, 32'(nbusy), 32'(w));
        chk_eq({name, "_diff_held"}, {31'd0, held}, 32'd1);
        if (m_done) begin
            sb_check(name);
        end else begin
            sb.delete();
        end
        @(negedge clk);
        chk_eq({name, "_done_pulse"}, {31'd0, m_done}, 32'd0);
    endtask

    vec_t v8[8];
    vec_t v1[4];

    initial begin
        int d1;
        int d2;
        int ndone;
        exp_t e;

        v8[0] = '{8'd10,  8'd3,   8'd7,   1'b0};
        v8[1] = '{8'd3,   8'd10,  8'hF9,  1'b1};
        v8[2] = '{8'h00,  8'h01,  8'hFF,  1'b1};
        v8[3] = '{8'hA5,  8'hA5,  8'h00,  1'b0};
        v8[4] = '{8'hFF,  8'h00,  8'hFF,  1'b0};
        v8[5] = '{8'h00,  8'hFF,  8'h01,  1'b1};
        v8[6] = '{8'h80,  8'h7F,  8'h01,  1'b0};
        v8[7] = '{8'h7F,  8'h80,  8'hFF,  1'b1};
        v1[0] = '{8'd0, 8'd0, 8'd0, 1'b0};
        v1[1] = '{8'd0, 8'd1, 8'd1, 1'b1};
        v1[2] = '{8'd1, 8'd0, 8'd1, 1'b0};
        v1[3] = '{8'd1, 8'd1, 8'd0, 1'b0};

        rst     = 1'b1;
        cur     = 1'b0;
        start_r = 1'b0;
        a_r     = 8'd0;
        b_r     = 8'd0;
        repeat (2) @(negedge clk);
        chk_eq("reset_busy8",   {31'd0, bus8.busy}, 32'd0);
        chk_eq("reset_done8",   {31'd0, bus8.done}, 32'd0);
        chk_eq("reset_diff8",   {24'd0, bus8.diff}, 32'd0);
        chk_eq("reset_borrow8", {31'd0, bus8.borrow_out}, 32'd0);
        chk_eq("reset_busy1",   {31'd0, bus1.busy}, 32'd0);
        chk_eq("reset_diff1",   {31'd0, bus1.diff}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors, 8-bit instance
        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, v8[i].a, v8[i].b, v8[i].diff, v8[i].bor, $sformatf("w8_vec%0d", i));
        end

        // Exhaustive half-subtractor truth table, 1-bit instance
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, v1[i].a, v1[i].b, v1[i].diff, v1[i].bor, $sformatf("w1_vec%0d", i));
        end

        // start held high; operands change mid-operation
        @(negedge clk);
        cur     = 1'b0;
        a_r     = 8'd10;
        b_r     = 8'd3;
        start_r = 1'b1;
        e.diff  = 8'd7;   e.bor = 1'b0; sb.push_back(e);
        e.diff  = 8'd226; e.bor = 1'b1; sb.push_back(e);
        d1 = -1;
        d2 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) begin
                a_r = 8'd20;
                b_r = 8'd50;
            end
            if (m_done) begin
                if (d1 < 0) begin
                    d1 = n;
                    sb_check("held_first");
                end else begin
                    d2 = n;
                    start_r = 1'b0;
                    sb_check("held_second");
                    break;
                end
            end
        end
        start_r = 1'b0;
        sb.delete();
        chk_eq("held_first_latency", 32'(d1), 32'd9);
        chk_eq("held_period", 32'(d2 - d1), 32'd10);
        repeat (2) @(negedge clk);

        // Reset asserted during the fourth SHIFT cycle
        @(negedge clk);
        a_r     = 8'd200;
        b_r     = 8'd55;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("pre_rst_busy", {31'd0, m_busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_eq("mid_rst_busy",   {31'd0, m_busy}, 32'd0);
        chk_eq("mid_rst_done",   {31'd0, m_done}, 32'd0);
        chk_eq("mid_rst_diff",   {24'd0, m_diff}, 32'd0);
        chk_eq("mid_rst_borrow", {31'd0, m_bor},  32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_done) ndone++;
        end
        chk_eq("rst_no_done", 32'(ndone), 32'd0);
        run_op(1'b0, 8'd200, 8'd55, 8'd145, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
